// File: rtl/hilo_mdu_ctrl.sv
// HI/LO sequencer: iterative signed/unsigned multiply and divide plus MTHI/MTLO merges,
// with a single HI/LO write port and a pipeline stall request while a mul/div is in flight.
module hilo_mdu_ctrl #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          annul,
  input  logic [DW-1:0] hi_cur,
  input  logic [DW-1:0] lo_cur,
  output logic          stall_req,
  output logic          busy,
  output logic          done,
  output logic          hilo_en,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] acc_hi_q, acc_hi_d;
  logic [DW-1:0] acc_lo_q, acc_lo_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  logic          is_muldiv, op_signed, a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;

  assign is_muldiv = ~op[2];
  assign op_signed = ~op[0];
  assign a_neg     = op_signed & src_a[DW-1];
  assign b_neg     = op_signed & src_b[DW-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  // Multiply step: {acc_hi, acc_lo} holds the partial product, multiplier shifts out of acc_lo.
  logic [DW:0]   mul_sum;
  logic [DW-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_n = mul_sum[DW:1];
  assign mul_lo_n = {mul_sum[0], acc_lo_q[DW-1:1]};

  // Restoring divide step: DW+1 bit partial remainder; quotient bits shift into acc_lo.
  logic [DW:0]   div_sh, div_diff;
  logic          div_ge;
  logic [DW-1:0] div_hi_n, div_lo_n;
  assign div_sh   = {acc_hi_q, acc_lo_q[DW-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[DW];
  assign div_hi_n = div_ge ? div_diff[DW-1:0] : div_sh[DW-1:0];
  assign div_lo_n = {acc_lo_q[DW-2:0], div_ge};

  logic [DW-1:0]   step_hi, step_lo;
  logic [2*DW-1:0] prod, prod_fix;
  assign step_hi  = is_div_q ? div_hi_n : mul_hi_n;
  assign step_lo  = is_div_q ? div_lo_n : mul_lo_n;
  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_res_q ? -prod : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    wr_d      = wr_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && !annul) begin
          if (is_muldiv) begin
            if (op[1] && src_b == '0) begin
              state_d = StDone;
              wr_d    = 1'b0;
            end else begin
              state_d   = StRun;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              acc_hi_d  = '0;
              acc_lo_d  = op[1] ? a_mag : b_mag;
              opnd_d    = op[1] ? b_mag : a_mag;
            end
          end else if (!op[1]) begin
            state_d = StDone;
            wr_d    = 1'b1;
            hi_d    = op[0] ? hi_cur : src_a;
            lo_d    = op[0] ? src_a : lo_cur;
          end
        end
      end
      StRun: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_d = StDone;
            wr_d    = 1'b1;
            if (is_div_q) begin
              hi_d = neg_rem_q ? -step_hi : step_hi;
              lo_d = neg_res_q ? -step_lo : step_lo;
            end else begin
              hi_d = prod_fix[2*DW-1:DW];
              lo_d = prod_fix[DW-1:0];
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      wr_q      <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      wr_q      <= wr_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign hilo_en = done & wr_q & ~annul;
  // Gated by rst so the request drops while the block is held in reset.
  assign stall_req = rst & ((state_q == StRun) | ((state_q == StIdle) & start & is_muldiv));
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Sequencer for the HI/LO register pair: accepts multiply, divide and move-to-HI/LO requests from the EX stage and writes results through the HI/LO write port (single enable, both halves written together).
- MULT/MULTU/DIV/DIVU run on an iterative shift-add / restoring-divide datapath inside this block.
- Pipeline stall is requested while an operation is in flight.
- MTHI/MTLO merge the operand with the current HI/LO contents so the untouched half is preserved.

Parameters:
DW, 32, operand/register width (HI and LO each DW bits)
CW, 6, iteration counter width (must hold DW)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request valid from EX; sampled only in IDLE
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
src_a  in  DW  rs operand (multiplicand / dividend / move source)
src_b  in  DW  rt operand (multiplier / divisor)
annul  in  1  flush of the owning instruction (exception/branch squash)
hi_cur  in  DW  current HI register value
lo_cur  in  DW  current LO register value
stall_req  out  1  hold pipeline while a mul/div is accepted or iterating
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in DONE state (also on div-by-zero)
hilo_en  out  1  HI/LO write enable
hi_out  out  DW  value to write into HI
lo_out  out  DW  value to write into LO

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst). While rst=0:
  - state=IDLE, counter=0
  - hi_out=0, lo_out=0, hilo_en=0, done=0, busy=0, stall_req=0
  - internal accumulators cleared
  - reset mid-operation aborts with no write.
- States: IDLE, RUN, DONE.
- IDLE, start=1, annul=0:
  - mul/div op: latch op; latch |src_a|, |src_b| (magnitudes for signed ops, raw for unsigned); latch sign flags; counter=0; go to RUN.
  - MTHI: hi_out=src_a, lo_out=lo_cur; go to DONE.
  - MTLO: hi_out=hi_cur, lo_out=src_a; go to DONE.
  - op 11x, or start with annul=1: stay in IDLE.
- stall_req is combinational: 1 in RUN; 1 in IDLE when start=1 and op is mul/div; 0 otherwise (including DONE and MTHI/MTLO).
- Divide by zero (DIV/DIVU with src_b=0): go directly to DONE with the write suppressed. done pulses, hilo_en stays 0, HI/LO are unchanged.
- RUN, multiply: 64-bit shift-add, one multiplier bit per cycle, DW cycles.
- RUN, divide: restoring division with a DW+1 bit partial remainder, one quotient bit per cycle, DW cycles.
- After the DW-th iteration (counter==DW-1), apply the sign fix and register the results:
  - multiply: if signs differ, negate the 64-bit product; {hi_out, lo_out} = product.
  - divide: lo_out = quotient, negated if signs differ; hi_out = remainder, negated if dividend negative.
  - go to DONE.
- Latency: start accepted at edge E0; results registered at edge E32; DONE for the cycle after E32; HI/LO written at E33. stall_req is high from acceptance through the cycle before DONE.
- DONE:
  - hilo_en = !annul (combinational), done=1 for one cycle.
  - return to IDLE next edge.
  - start in DONE is ignored; the requester holds it and is accepted in IDLE.
- annul in RUN: return to IDLE at the next edge, no write, outputs keep their last values.
- start while busy: ignored.
- Arithmetic: all subtracts/negations are modulo 2^DW (or 2^2DW for the product). Signed INT_MIN / -1 gives quotient 0x80000000, remainder 0; no trap.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> stall_req high for 33 cycles; hilo_en one cycle at cycle 33; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo_out=14, hi_out=2. DIV -7/2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- DIV src_b=0 -> done pulses, hilo_en never asserted, busy back to 0 within 2 cycles.
- MTHI src_a=0xA5A5A5A5, hi_cur=1, lo_cur=0x1234 -> next cycle hilo_en=1, hi_out=0xA5A5A5A5, lo_out=0x1234, stall_req never high. MTLO mirrors this.
- annul at iteration 10 of a MULT -> IDLE next edge, no hilo_en; an immediate new DIVU 9/3 -> lo=3, hi=0. annul during DONE -> hilo_en=0.
- rst low at iteration 20 of a DIV (asynchronously, mid-cycle) -> all outputs 0 immediately, no write; after release, MULTU 6*7 -> lo=42, hi=0.
